data_store_unit: RTL and testbench

- Write-side counterpart of the instruction fetch path.
- Accepts word/half/byte store requests from the core through a valid/ready handshake and buffers them.
- Serialises each request into one-byte-per-cycle writes on a byte-wide memory port, most-significant byte first (big-endian).
- Sits between the execute stage and the byte-addressed main memory.

---
 rtl/store_pkg.sv | 30 +++
 rtl/data_store_unit_fifo.sv | 55 +++++
 rtl/data_store_unit.sv | 187 ++++++++++++++++++
 tb/tb_data_store_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared types for the byte-serialising store unit: request sizes, FSM states and
// the size-to-byte-count mapping.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } store_size_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WRITE = 2'b01,
    S_DONE  = 2'b10
  } store_state_e;

  // Reserved size yields zero bytes; such requests never enter the write phase.
  function automatic logic [2:0] size_bytes(input store_size_e sz);
    logic [2:0] n;
    unique case (sz)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/data_store_unit_fifo.sv
// Synchronous FIFO with a synchronous active-low reset. Depth must be a power of two;
// pushes while full and pops while empty are ignored. Read data is the current head.
module data_store_unit_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full_o   = (count_q == (PtrW+1)'(Depth));
    empty_o  = (count_q == '0);
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    rdata_o  = mem_q[rd_ptr_q];
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/data_store_unit.sv
// Buffers byte/half/word store requests and writes them one byte per cycle, MSB first,
// to a byte-wide memory port. Define STORE_ALIGN_CHECK_EN to reject misaligned half/word.
module data_store_unit
  import store_pkg::*;
#(
  parameter int unsigned depth        = 8,
  parameter int unsigned address_size = 32,
  parameter int unsigned width        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [address_size-1:0] req_addr,
  input  logic [width-1:0]        req_data,
  input  logic [1:0]              req_size,
  input  logic                    stall,
  output logic                    mem_we,
  output logic [address_size-1:0] mem_addr,
  output logic [7:0]              mem_wdata,
  output logic                    done,
  output logic                    err,
  output logic                    busy
);

  localparam int unsigned EntryW = address_size + width + 2;

  logic [EntryW-1:0]       fifo_wdata, fifo_rdata;
  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [address_size-1:0] head_addr;
  logic [width-1:0]        head_data;
  store_size_e             head_size;
  logic                    head_reject;

  store_state_e            state_q, state_d;
  logic [address_size-1:0] base_q, base_d;
  logic [width-1:0]        data_q, data_d;
  logic [2:0]              nbytes_q, nbytes_d;
  logic [2:0]              idx_q, idx_d;
  logic                    rej_q, rej_d;

  logic                    mem_we_q, mem_we_d;
  logic [address_size-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]              mem_wdata_q, mem_wdata_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    last_byte;
  logic [2:0]              byte_sel;
  logic [width-1:0]        data_shifted;

  // Held low in reset so nothing is offered as accepted while the unit is cleared.
  assign req_ready  = rst & ~fifo_full;
  assign fifo_push  = req_valid & req_ready;
  assign fifo_wdata = {req_addr, req_data, req_size};
  assign fifo_pop   = (state_q == S_IDLE) & ~fifo_empty;

  assign head_addr  = fifo_rdata[EntryW-1 -: address_size];
  assign head_data  = fifo_rdata[2 +: width];
  assign head_size  = store_size_e'(fifo_rdata[1:0]);

  always_comb begin
    head_reject = (head_size == SZ_RSVD);
`ifdef STORE_ALIGN_CHECK_EN
    if ((head_size == SZ_HALF) && head_addr[0]) begin
      head_reject = 1'b1;
    end
    if ((head_size == SZ_WORD) && (head_addr[1:0] != 2'b00)) begin
      head_reject = 1'b1;
    end
`endif
  end

  data_store_unit_fifo #(
    .Width(EntryW),
    .Depth(depth)
  ) u_req_fifo (
    .clk_i  (clk),
    .rst_ni (rst),
    .push_i (fifo_push),
    .wdata_i(fifo_wdata),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign last_byte = (idx_q == nbytes_q - 3'd1);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = head_reject ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        if (!stall && last_byte) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Working registers for the request being serialised.
  always_comb begin
    base_d   = base_q;
    data_d   = data_q;
    nbytes_d = nbytes_q;
    idx_d    = idx_q;
    rej_d    = rej_q;
    if (fifo_pop) begin
      base_d   = head_addr;
      data_d   = head_data;
      nbytes_d = size_bytes(head_size);
      idx_d    = '0;
      rej_d    = head_reject;
    end else if ((state_q == S_WRITE) && !stall) begin
      idx_d = idx_q + 3'd1;
    end
  end

  // Registered outputs; address and data hold their last value between writes.
  always_comb begin
    byte_sel     = nbytes_q - 3'd1 - idx_q;
    data_shifted = data_q >> {byte_sel, 3'b000};
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    unique case (state_q)
      S_WRITE: begin
        if (!stall) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = base_q + address_size'(idx_q);
          mem_wdata_d = data_shifted[7:0];
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        err_d  = rej_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      data_q      <= '0;
      nbytes_q    <= '0;
      idx_q       <= '0;
      rej_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      data_q      <= data_d;
      nbytes_q    <= nbytes_d;
      idx_q       <= idx_d;
      rej_q       <= rej_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_data_store_unit.sv
// Bench for data_store_unit: transaction-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_data_store_unit;

  localparam int unsigned Depth = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic        stall = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        done, err, busy;

  always #5 clk = ~clk;

  data_store_unit #(
    .depth       (Depth),
    .address_size(32),
    .width       (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_size (req_size),
    .stall    (stall),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .done     (done),
    .err      (err),
    .busy     (busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {logic [31:0] addr; logic [31:0] data; logic [1:0] size;} req_t;
  typedef struct {logic [31:0] addr; logic [7:0] data; int cyc;} wr_t;
  typedef struct {int cyc; logic err;} dn_t;

  // Reference model: queue of accepted requests plus the one being written.
  req_t        mq[$];
  req_t        cur;
  int          phase = 0;  // 0 waiting, 1 writing bytes, 2 retiring
  int          idx = 0;
  logic        m_we = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = '0;
  logic [7:0]  m_wdata = '0;
  bit          model_valid = 1'b0;

  wr_t wr_log[$];
  dn_t dn_log[$];

  function automatic int nbytes(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit rejected(input req_t r);
    if (r.size == 2'b11) return 1'b1;
`ifdef STORE_ALIGN_CHECK_EN
    if (r.size == 2'b01 && r.addr[0]) return 1'b1;
    if (r.size == 2'b10 && r.addr[1:0] != 2'b00) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/missing expected event (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) begin
    bit   rdy;
    req_t nr;
    int   n;
    cyc++;
    rdy = rst && (mq.size() < Depth);
    if (!rst) begin
      mq.delete();
      phase = 0; idx = 0;
      m_we = 1'b0; m_done = 1'b0; m_err = 1'b0; m_addr = '0; m_wdata = '0;
      model_valid = 1'b1;
    end else begin
      m_we = 1'b0; m_done = 1'b0; m_err = 1'b0;
      if (phase == 0) begin
        if (mq.size() > 0) begin
          cur = mq.pop_front();
          idx = 0;
          phase = rejected(cur) ? 2 : 1;
        end
      end else if (phase == 1) begin
        if (!stall) begin
          n = nbytes(cur.size);
          m_we = 1'b1;
          m_addr = cur.addr + 32'(idx);
          m_wdata = 8'(cur.data >> (8 * (n - 1 - idx)));
          idx++;
          if (idx == n) phase = 2;
        end
      end else begin
        m_done = 1'b1;
        m_err = rejected(cur);
        phase = 0;
      end
      if (req_valid && rdy) begin
        nr.addr = req_addr; nr.data = req_data; nr.size = req_size;
        mq.push_back(nr);
      end
    end
  end

  always @(negedge clk) begin
    wr_t w;
    dn_t d;
    if (model_valid) begin
      chk("req_ready", 64'(req_ready), 64'(rst && (mq.size() < Depth)));
      chk("mem_we", 64'(mem_we), 64'(m_we));
      chk("mem_addr", 64'(mem_addr), 64'(m_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
      chk("done", 64'(done), 64'(m_done));
      chk("err", 64'(err), 64'(m_err));
      chk("busy", 64'(busy), 64'((phase != 0) || (mq.size() != 0)));
      if (mem_we === 1'b1) begin
        w.addr = mem_addr; w.data = mem_wdata; w.cyc = cyc;
        wr_log.push_back(w);
      end
      if (done === 1'b1) begin
        d.cyc = cyc; d.err = err;
        dn_log.push_back(d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                      output int t);
    int lim = 0;
    req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
    while (req_ready !== 1'b1 && lim < 200) begin
      tick();
      lim++;
    end
    if (lim >= 200) fail("send_timeout");
    @(posedge clk);
    #1 t = cyc;
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int lim = 0;
    while ((busy !== 1'b0 || phase != 0 || mq.size() != 0) && lim < 500) begin
      tick();
      lim++;
    end
    if (lim >= 500) fail("idle_timeout");
    tick();
    tick();
  endtask

  task automatic expect_wr(input string tag, input int k, input logic [31:0] a,
                           input logic [7:0] d);
    if (k < wr_log.size()) begin
      chk({tag, "_addr"}, 64'(wr_log[k].addr), 64'(a));
      chk({tag, "_data"}, 64'(wr_log[k].data), 64'(d));
    end else begin
      fail({tag, "_missing"});
    end
  endtask

  task automatic clear_logs();
    wr_log.delete();
    dn_log.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   t, t0;
    bit   full_seen;
    logic [31:0] wd;

    // Reset with a request pending: nothing may be accepted.
    rst = 1'b0; req_valid = 1'b1; req_size = 2'b10; req_addr = 32'h55; req_data = 32'h1;
    tick(); tick(); tick();
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_we", 64'(mem_we), 64'(0));
    rst = 1'b1; req_valid = 1'b0;
    tick();
    chk("post_rst_ready", 64'(req_ready), 64'(1));
    chk("post_rst_busy", 64'(busy), 64'(0));

    // Word store.
    clear_logs();
    send(32'h100, 32'hDEADBEEF, 2'b10, t);
    wait_idle();
    chk("w_nwr", 64'(wr_log.size()), 64'(4));
    expect_wr("w0", 0, 32'h100, 8'hDE);
    expect_wr("w1", 1, 32'h101, 8'hAD);
    expect_wr("w2", 2, 32'h102, 8'hBE);
    expect_wr("w3", 3, 32'h103, 8'hEF);
    if (wr_log.size() == 4) begin
      chk("w_first_cyc", 64'(wr_log[0].cyc), 64'(t + 2));
      chk("w_last_cyc", 64'(wr_log[3].cyc), 64'(t + 5));
    end
    chk("w_ndone", 64'(dn_log.size()), 64'(1));
    if (dn_log.size() == 1) begin
      chk("w_done_cyc", 64'(dn_log[0].cyc), 64'(t + 6));
      chk("w_done_err", 64'(dn_log[0].err), 64'(0));
    end

    // Half then byte, in order.
    clear_logs();
    send(32'h201, 32'h0000_1234, 2'b01, t);
    send(32'h300, 32'h0000_00A5, 2'b00, t);
    wait_idle();
    chk("hb_ndone", 64'(dn_log.size()), 64'(2));
`ifdef STORE_ALIGN_CHECK_EN
    chk("hb_nwr", 64'(wr_log.size()), 64'(1));
    expect_wr("hb_b", 0, 32'h300, 8'hA5);
    if (dn_log.size() == 2) chk("hb_err0", 64'(dn_log[0].err), 64'(1));
`else
    chk("hb_nwr", 64'(wr_log.size()), 64'(3));
    expect_wr("hb_h0", 0, 32'h201, 8'h12);
    expect_wr("hb_h1", 1, 32'h202, 8'h34);
    expect_wr("hb_b", 2, 32'h300, 8'hA5);
    if (dn_log.size() == 2 && wr_log.size() == 3)
      chk("hb_order", 64'(dn_log[0].cyc > wr_log[1].cyc && dn_log[0].cyc < wr_log[2].cyc),
          64'(1));
    if (dn_log.size() == 2) chk("hb_err0", 64'(dn_log[0].err), 64'(0));
`endif
    if (dn_log.size() == 2) chk("hb_err1", 64'(dn_log[1].err), 64'(0));

    // Back-to-back words overrun the buffer; all retire in order.
    clear_logs();
    full_seen = 1'b0;
    for (int k = 0; k < Depth + 4; k++) begin
      if (req_ready !== 1'b1) full_seen = 1'b1;
      send(32'h1000 + 32'(4 * k), 32'h0101_0101 * 32'(k + 1), 2'b10, t);
      if (req_ready !== 1'b1) full_seen = 1'b1;
    end
    wait_idle();
    chk("b2b_full_seen", 64'(full_seen), 64'(1));
    chk("b2b_nwr", 64'(wr_log.size()), 64'(4 * (Depth + 4)));
    chk("b2b_ndone", 64'(dn_log.size()), 64'(Depth + 4));
    for (int k = 0; k < Depth + 4; k++) begin
      wd = 32'h0101_0101 * 32'(k + 1);
      for (int j = 0; j < 4; j++)
        expect_wr("b2b", 4 * k + j, 32'h1000 + 32'(4 * k + j), 8'(wd >> (8 * (3 - j))));
    end

    // Stall three cycles in front of byte 2.
    clear_logs();
    send(32'h400, 32'h1122_3344, 2'b10, t0);
    while (cyc < t0 + 3) tick();
    stall = 1'b1;
    tick(); tick(); tick();
    stall = 1'b0;
    wait_idle();
    chk("st_nwr", 64'(wr_log.size()), 64'(4));
    expect_wr("st2", 2, 32'h402, 8'h33);
    expect_wr("st3", 3, 32'h403, 8'h44);
    if (wr_log.size() == 4) begin
      chk("st_gap", 64'(wr_log[2].cyc - wr_log[1].cyc), 64'(4));
      chk("st_window", 64'(wr_log[3].cyc - wr_log[0].cyc + 1), 64'(7));
    end

    // Word at the top of the address space.
    clear_logs();
    send(32'hFFFF_FFFE, 32'hCAFE_F00D, 2'b10, t);
    wait_idle();
    chk("wrap_ndone", 64'(dn_log.size()), 64'(1));
`ifdef STORE_ALIGN_CHECK_EN
    chk("wrap_nwr", 64'(wr_log.size()), 64'(0));
    if (dn_log.size() == 1) chk("wrap_err", 64'(dn_log[0].err), 64'(1));
`else
    chk("wrap_nwr", 64'(wr_log.size()), 64'(4));
    expect_wr("wrap0", 0, 32'hFFFF_FFFE, 8'hCA);
    expect_wr("wrap1", 1, 32'hFFFF_FFFF, 8'hFE);
    expect_wr("wrap2", 2, 32'h0000_0000, 8'hF0);
    expect_wr("wrap3", 3, 32'h0000_0001, 8'h0D);
    if (dn_log.size() == 1) chk("wrap_err", 64'(dn_log[0].err), 64'(0));
`endif

    // Reserved size.
    clear_logs();
    send(32'h500, 32'h1234_5678, 2'b11, t);
    wait_idle();
    chk("rsvd_nwr", 64'(wr_log.size()), 64'(0));
    chk("rsvd_ndone", 64'(dn_log.size()), 64'(1));
    if (dn_log.size() == 1) chk("rsvd_err", 64'(dn_log[0].err), 64'(1));

    // Randomized traffic with stalls and one reset mid-stream.
    for (int c = 0; c < 1500; c++) begin
      rst       = !(c == 700 || c == 701);
      req_valid = ($urandom_range(0, 1) == 1);
      req_size  = 2'($urandom_range(0, 3));
      req_addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                : $urandom();
      req_data  = $urandom();
      stall     = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 1'b1; req_valid = 1'b0; stall = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
